// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_port_arbiter                                             |
// | Description : Shares one 1RW 64-bit SRAM macro between instruction fetch,  |
// |               dcache load and dcache store. Single-cycle combinational     |
// |               grant, 1-cycle read response steered back by a read tag.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mem_port_arbiter #(
   parameter int XLEN         = 64,
   parameter int ADDR_WIDTH   = 17,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  rst,

   input  logic                  fetch_addr_valid,
   output logic                  fetch_addr_ready,
   input  logic [XLEN-1:0]       fetch_addr,
   output logic                  fetch_data_valid,
   output logic [31:0]           fetch_data,

   input  logic                  load_a_valid,
   output logic                  load_a_ready,
   input  logic [XLEN-1:0]       load_a_addr,
   output logic                  load_d_valid,
   output logic [63:0]           load_d_data,

   input  logic                  st_valid,
   output logic                  st_ready,
   input  logic [XLEN-1:0]       st_addr,
   input  logic [63:0]           st_data,
   input  logic [7:0]            st_mask,

   output logic                  sram_ce,
   output logic                  sram_we,
   output logic [ADDR_WIDTH-1:0] sram_addr,
   output logic [63:0]           sram_wdata,
   output logic [7:0]            sram_wmask,
   input  logic [63:0]           sram_rdata
);

   localparam int                 c_cnt_w      = $clog2(STARVE_LIMIT + 1);
   localparam logic [c_cnt_w-1:0] c_starve_max = c_cnt_w'(STARVE_LIMIT);

   // Which requester owns the read data returning from the SRAM this cycle.
   typedef enum logic [1:0] {
      SRC_NONE  = 2'd0,
      SRC_FETCH = 2'd1,
      SRC_LOAD  = 2'd2
   } rd_src_e;

   rd_src_e            rd_src_q, rd_src_d;
   logic               bo_q, bo_d;
   logic [c_cnt_w-1:0] starve_cnt_q, starve_cnt_d;

   logic               w_fetch_promote;
   logic               w_gnt_fetch;
   logic               w_gnt_load;
   logic               w_gnt_st;

   // Word-address bits outside the SRAM range and the byte offsets are not
   // needed by the macro; fetch_addr[2] is kept separately for half-word select.
   logic               unused_addr_bits;
   assign unused_addr_bits = ^{fetch_addr[XLEN-1:ADDR_WIDTH+3], fetch_addr[1:0],
                               load_a_addr[XLEN-1:ADDR_WIDTH+3], load_a_addr[2:0],
                               st_addr[XLEN-1:ADDR_WIDTH+3], st_addr[2:0]};

   // Fixed-priority grant (store > load > fetch) with a starvation override for fetch.
   always_comb begin
      w_fetch_promote = fetch_addr_valid && (starve_cnt_q == c_starve_max);
      w_gnt_fetch     = 1'b0;
      w_gnt_load      = 1'b0;
      w_gnt_st        = 1'b0;
      if (!rst) begin
         if (w_fetch_promote) begin
            w_gnt_fetch = 1'b1;
         end else if (st_valid) begin
            w_gnt_st = 1'b1;
         end else if (load_a_valid) begin
            w_gnt_load = 1'b1;
         end else if (fetch_addr_valid) begin
            w_gnt_fetch = 1'b1;
         end
      end
   end

   assign fetch_addr_ready = w_gnt_fetch;
   assign load_a_ready     = w_gnt_load;
   assign st_ready         = w_gnt_st;

   // Drive the SRAM macro from whichever request won this cycle.
   always_comb begin
      sram_ce    = w_gnt_fetch | w_gnt_load | w_gnt_st;
      sram_we    = w_gnt_st;
      sram_addr  = '0;
      sram_wdata = '0;
      sram_wmask = '0;
      if (w_gnt_st) begin
         sram_addr  = st_addr[ADDR_WIDTH+2:3];
         sram_wdata = st_data;
         sram_wmask = st_mask;
      end else if (w_gnt_load) begin
         sram_addr = load_a_addr[ADDR_WIDTH+2:3];
      end else if (w_gnt_fetch) begin
         sram_addr = fetch_addr[ADDR_WIDTH+2:3];
      end
   end

   // Next read tag, half-word select and starvation count.
   always_comb begin
      rd_src_d     = SRC_NONE;
      bo_d         = bo_q;
      starve_cnt_d = starve_cnt_q;
      if (w_gnt_fetch) begin
         rd_src_d = SRC_FETCH;
         bo_d     = fetch_addr[2];
      end else if (w_gnt_load) begin
         rd_src_d = SRC_LOAD;
         bo_d     = fetch_addr[2];
      end
      if (!fetch_addr_valid || w_gnt_fetch) begin
         starve_cnt_d = '0;
      end else if (starve_cnt_q != c_starve_max) begin
         starve_cnt_d = starve_cnt_q + 1'b1;
      end
   end

   // State registers; reset drops any in-flight read tag.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_src_q     <= SRC_NONE;
         bo_q         <= 1'b0;
         starve_cnt_q <= '0;
      end else begin
         rd_src_q     <= rd_src_d;
         bo_q         <= bo_d;
         starve_cnt_q <= starve_cnt_d;
      end
   end

   assign fetch_data_valid = (rd_src_q == SRC_FETCH);
   assign load_d_valid     = (rd_src_q == SRC_LOAD);
   assign fetch_data       = bo_q ? sram_rdata[63:32] : sram_rdata[31:0];
   assign load_d_data      = sram_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mem_port_arbiter                                          |
// | Description : Directed self-checking bench for mem_port_arbiter with a     |
// |               small behavioural 1RW SRAM model (1-cycle read latency).     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mem_port_arbiter;

   logic        clk;
   logic        rst;
   logic        fetch_addr_valid;
   logic        fetch_addr_ready;
   logic [63:0] fetch_addr;
   logic        fetch_data_valid;
   logic [31:0] fetch_data;
   logic        load_a_valid;
   logic        load_a_ready;
   logic [63:0] load_a_addr;
   logic        load_d_valid;
   logic [63:0] load_d_data;
   logic        st_valid;
   logic        st_ready;
   logic [63:0] st_addr;
   logic [63:0] st_data;
   logic [7:0]  st_mask;
   logic        sram_ce;
   logic        sram_we;
   logic [16:0] sram_addr;
   logic [63:0] sram_wdata;
   logic [7:0]  sram_wmask;
   logic [63:0] sram_rdata;

   // Backdoor preload port into the SRAM model
   logic        bd_en;
   logic [9:0]  bd_addr;
   logic [63:0] bd_data;

   int checks = 0;
   int errors = 0;

   mem_port_arbiter #(
      .XLEN         (64),
      .ADDR_WIDTH   (17),
      .STARVE_LIMIT (4)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .fetch_addr_valid (fetch_addr_valid),
      .fetch_addr_ready (fetch_addr_ready),
      .fetch_addr       (fetch_addr),
      .fetch_data_valid (fetch_data_valid),
      .fetch_data       (fetch_data),
      .load_a_valid     (load_a_valid),
      .load_a_ready     (load_a_ready),
      .load_a_addr      (load_a_addr),
      .load_d_valid     (load_d_valid),
      .load_d_data      (load_d_data),
      .st_valid         (st_valid),
      .st_ready         (st_ready),
      .st_addr          (st_addr),
      .st_data          (st_data),
      .st_mask          (st_mask),
      .sram_ce          (sram_ce),
      .sram_we          (sram_we),
      .sram_addr        (sram_addr),
      .sram_wdata       (sram_wdata),
      .sram_wmask       (sram_wmask),
      .sram_rdata       (sram_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // 1RW SRAM model: masked byte writes, registered read data.
   logic [63:0] mem [0:1023];
   always @(posedge clk) begin
      if (bd_en) begin
         mem[bd_addr] <= bd_data;
      end else if (sram_ce) begin
         if (sram_we) begin
            for (int b = 0; b < 8; b++) begin
               if (sram_wmask[b]) mem[sram_addr[9:0]][8*b +: 8] <= sram_wdata[8*b +: 8];
            end
         end else begin
            sram_rdata <= mem[sram_addr[9:0]];
         end
      end
   end

   task automatic preload(input logic [9:0] a, input logic [63:0] d);
      @(negedge clk);
      bd_en   = 1'b1;
      bd_addr = a;
      bd_data = d;
      @(negedge clk);
      bd_en   = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      #1;
      checks++; if ({fetch_addr_ready, load_a_ready, st_ready} !== 3'b000) begin errors++;
         $display("FAIL reset_readies: got %b expected 000", {fetch_addr_ready, load_a_ready, st_ready}); end
      checks++; if (sram_ce !== 1'b0) begin errors++;
         $display("FAIL reset_sram_ce: got %b expected 0", sram_ce); end
      @(negedge clk);
      rst              = 1'b0;
      fetch_addr_valid = 1'b0;
      load_a_valid     = 1'b0;
      st_valid         = 1'b0;
      #1;
      checks++; if ({fetch_data_valid, load_d_valid} !== 2'b00) begin errors++;
         $display("FAIL reset_resp_valid: got %b expected 00", {fetch_data_valid, load_d_valid}); end
      checks++; if (sram_ce !== 1'b0) begin errors++;
         $display("FAIL idle_sram_ce: got %b expected 0", sram_ce); end
   endtask

   task automatic test_fetch_pair();
      preload(10'h20, 64'hAAAAAAAA_55555555);
      @(negedge clk);
      fetch_addr_valid = 1'b1;
      fetch_addr       = 64'h100;
      #1;
      checks++; if (fetch_addr_ready !== 1'b1) begin errors++;
         $display("FAIL fetch0_ready: got %b expected 1", fetch_addr_ready); end
      checks++; if ({sram_ce, sram_we, sram_addr} !== {1'b1, 1'b0, 17'h20}) begin errors++;
         $display("FAIL fetch0_sram: got ce=%b we=%b addr=%h expected ce=1 we=0 addr=00020", sram_ce, sram_we, sram_addr); end
      @(negedge clk);
      fetch_addr = 64'hDEAD_0000_0000_0104;   // upper bits must be ignored
      #1;
      checks++; if (fetch_addr_ready !== 1'b1) begin errors++;
         $display("FAIL fetch1_ready: got %b expected 1", fetch_addr_ready); end
      checks++; if (sram_addr !== 17'h20) begin errors++;
         $display("FAIL fetch1_upper_addr: got %h expected 00020", sram_addr); end
      checks++; if ({fetch_data_valid, fetch_data} !== {1'b1, 32'h55555555}) begin errors++;
         $display("FAIL fetch0_data: got v=%b d=%h expected v=1 d=55555555", fetch_data_valid, fetch_data); end
      @(negedge clk);
      fetch_addr_valid = 1'b0;
      #1;
      checks++; if ({fetch_data_valid, fetch_data} !== {1'b1, 32'hAAAAAAAA}) begin errors++;
         $display("FAIL fetch1_data: got v=%b d=%h expected v=1 d=aaaaaaaa", fetch_data_valid, fetch_data); end
      @(negedge clk);
      #1;
      checks++; if (fetch_data_valid !== 1'b0) begin errors++;
         $display("FAIL fetch_idle_valid: got %b expected 0", fetch_data_valid); end
   endtask

   task automatic test_priority();
      @(negedge clk);
      st_valid         = 1'b1;
      st_addr          = 64'h200;
      st_data          = 64'h11223344_55667788;
      st_mask          = 8'hFF;
      load_a_valid     = 1'b1;
      load_a_addr      = 64'h200;
      fetch_addr_valid = 1'b1;
      fetch_addr       = 64'h100;
      #1;
      checks++; if ({st_ready, load_a_ready, fetch_addr_ready} !== 3'b100) begin errors++;
         $display("FAIL prio_c0_grant: got st/ld/f=%b expected 100", {st_ready, load_a_ready, fetch_addr_ready}); end
      checks++; if ({sram_we, sram_addr, sram_wdata, sram_wmask} !== {1'b1, 17'h40, 64'h11223344_55667788, 8'hFF}) begin errors++;
         $display("FAIL prio_c0_sram: got we=%b addr=%h wd=%h wm=%h expected we=1 addr=00040 wd=1122334455667788 wm=ff",
                  sram_we, sram_addr, sram_wdata, sram_wmask); end
      @(negedge clk);
      st_valid = 1'b0;
      #1;
      checks++; if ({st_ready, load_a_ready, fetch_addr_ready} !== 3'b010) begin errors++;
         $display("FAIL prio_c1_grant: got st/ld/f=%b expected 010", {st_ready, load_a_ready, fetch_addr_ready}); end
      checks++; if (sram_we !== 1'b0) begin errors++;
         $display("FAIL prio_c1_we: got %b expected 0", sram_we); end
      @(negedge clk);
      load_a_valid = 1'b0;
      #1;
      checks++; if ({st_ready, load_a_ready, fetch_addr_ready} !== 3'b001) begin errors++;
         $display("FAIL prio_c2_grant: got st/ld/f=%b expected 001", {st_ready, load_a_ready, fetch_addr_ready}); end
      checks++; if ({load_d_valid, load_d_data} !== {1'b1, 64'h11223344_55667788}) begin errors++;
         $display("FAIL prio_load_data: got v=%b d=%h expected v=1 d=1122334455667788", load_d_valid, load_d_data); end
      @(negedge clk);
      fetch_addr_valid = 1'b0;
      #1;
      checks++; if ({fetch_data_valid, load_d_valid, fetch_data} !== {2'b10, 32'h55555555}) begin errors++;
         $display("FAIL prio_fetch_data: got fv=%b lv=%b d=%h expected fv=1 lv=0 d=55555555",
                  fetch_data_valid, load_d_valid, fetch_data); end
   endtask

   task automatic test_starve();
      logic [9:0] fetch_gnt;
      fetch_gnt = 10'b10_0001_0000;   // fetch wins in cycles 4 and 9
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         load_a_valid     = 1'b1;
         load_a_addr      = 64'h200;
         fetch_addr_valid = 1'b1;
         fetch_addr       = 64'h104;
         #1;
         checks++; if ({load_a_ready, fetch_addr_ready} !== {~fetch_gnt[i], fetch_gnt[i]}) begin errors++;
            $display("FAIL starve_grant_c%0d: got ld/f=%b%b expected %b%b", i, load_a_ready, fetch_addr_ready,
                     ~fetch_gnt[i], fetch_gnt[i]); end
         if (i > 0) begin
            checks++; if ({fetch_data_valid, load_d_valid} !== {fetch_gnt[i-1], ~fetch_gnt[i-1]}) begin errors++;
               $display("FAIL starve_resp_c%0d: got fv/lv=%b%b expected %b%b", i, fetch_data_valid, load_d_valid,
                        fetch_gnt[i-1], ~fetch_gnt[i-1]); end
         end
         if (i == 1) begin
            checks++; if (load_d_data !== 64'h11223344_55667788) begin errors++;
               $display("FAIL starve_load_data: got %h expected 1122334455667788", load_d_data); end
         end
      end
      @(negedge clk);
      load_a_valid     = 1'b0;
      fetch_addr_valid = 1'b0;
      #1;
      checks++; if ({fetch_data_valid, fetch_data} !== {1'b1, 32'hAAAAAAAA}) begin errors++;
         $display("FAIL starve_fetch_data: got v=%b d=%h expected v=1 d=aaaaaaaa", fetch_data_valid, fetch_data); end
   endtask

   task automatic test_back_to_back_mask();
      preload(10'h40, 64'h0);
      @(negedge clk);
      st_valid = 1'b1;
      st_addr  = 64'h200;
      st_data  = 64'hFFFFFFFF_FFFFFFFF;
      st_mask  = 8'h0F;
      #1;
      checks++; if ({st_ready, sram_wmask} !== {1'b1, 8'h0F}) begin errors++;
         $display("FAIL mask_store: got rdy=%b wm=%h expected rdy=1 wm=0f", st_ready, sram_wmask); end
      @(negedge clk);
      st_valid     = 1'b0;
      load_a_valid = 1'b1;
      load_a_addr  = 64'h200;
      #1;
      checks++; if ({load_a_ready, sram_ce, sram_we} !== 3'b110) begin errors++;
         $display("FAIL b2b_load_grant: got rdy/ce/we=%b expected 110", {load_a_ready, sram_ce, sram_we}); end
      @(negedge clk);
      load_a_valid = 1'b0;
      #1;
      checks++; if ({load_d_valid, load_d_data} !== {1'b1, 64'h00000000_FFFFFFFF}) begin errors++;
         $display("FAIL mask_load_data: got v=%b d=%h expected v=1 d=00000000ffffffff", load_d_valid, load_d_data); end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      rst          = 1'b1;
      load_a_valid = 1'b1;
      load_a_addr  = 64'h200;
      #1;
      checks++; if ({load_a_ready, sram_ce} !== 2'b00) begin errors++;
         $display("FAIL rstmid_grant: got rdy/ce=%b expected 00", {load_a_ready, sram_ce}); end
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++; if (load_d_valid !== 1'b0) begin errors++;
         $display("FAIL rstmid_no_resp: got %b expected 0", load_d_valid); end
      checks++; if (load_a_ready !== 1'b1) begin errors++;
         $display("FAIL rstmid_reissue_ready: got %b expected 1", load_a_ready); end
      @(negedge clk);
      load_a_valid = 1'b0;
      #1;
      checks++; if ({load_d_valid, load_d_data} !== {1'b1, 64'h00000000_FFFFFFFF}) begin errors++;
         $display("FAIL rstmid_data: got v=%b d=%h expected v=1 d=00000000ffffffff", load_d_valid, load_d_data); end
      @(negedge clk);
      #1;
      checks++; if (load_d_valid !== 1'b0) begin errors++;
         $display("FAIL rstmid_idle: got %b expected 0", load_d_valid); end
   endtask

   initial begin
      rst              = 1'b1;
      bd_en            = 1'b0;
      bd_addr          = '0;
      bd_data          = '0;
      fetch_addr_valid = 1'b1;
      fetch_addr       = 64'h100;
      load_a_valid     = 1'b1;
      load_a_addr      = 64'h200;
      st_valid         = 1'b1;
      st_addr          = 64'h200;
      st_data          = '0;
      st_mask          = 8'hFF;

      test_reset();
      test_fetch_pair();
      test_priority();
      test_starve();
      test_back_to_back_mask();
      test_reset_mid();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
